etb_213: RTL

Traceback survivor-memory unit for the efficient (2,1,3) Viterbi decoder. It sits directly downstream of the four ACS cells and stores each cycle's 4-bit vector of backward-path decisions in a ring buffer. Once the buffer is full it traces back a fixed depth from a start state, emits one decoded bit, and stalls the ACS array with `ready` while it does so.

---
 rtl/etb_213_pkg.sv | 24 ++
 rtl/etb_213_if.sv | 27 ++
 rtl/etb_213_best_state.sv | 26 ++
 rtl/etb_213.sv | 118 +++++++++++
 4 files changed

// File: rtl/etb_213_pkg.sv
// etb_213 shared package: trellis constants, FSM encoding,
// parameter defaults and the predecessor-state helper.
package etb_213_pkg;

  localparam int K = 3;
  localparam int NS = 1 << (K - 1);
  localparam int W_DEF = 4;
  localparam int TB_DEPTH_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    TRACE,
    EMIT
  } etb_state_e;

  // s = {u_t, u_t-1}; decision b supplies u_t-2
  function automatic logic [1:0] pred(
    input logic [1:0] s,
    input logic b
  );
    return {s[0], b};
  endfunction

endpackage

// File: rtl/etb_213_if.sv
// etb_213 bus: ACS decision/metric offer (ae, acs_Bx, acs_ppm)
// and decoder results (ready, dout, dout_valid, ovf).
interface etb_213_if
  import etb_213_pkg::*;
#(
  parameter int W = W_DEF
);

  logic ae;
  logic [NS-1:0] acs_Bx;
  logic [NS*W-1:0] acs_ppm;
  logic ready;
  logic dout;
  logic dout_valid;
  logic ovf;

  modport master (
    output ae, acs_Bx, acs_ppm,
    input ready, dout, dout_valid, ovf
  );

  modport slave (
    input ae, acs_Bx, acs_ppm,
    output ready, dout, dout_valid, ovf
  );

endinterface

// File: rtl/etb_213_best_state.sv
// etb_best_state_213: index of the minimum of four W-bit metrics.
// Ports: ppm (4 packed metrics, slice s = state s), idx (winner).
module etb_best_state_213
  import etb_213_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic [NS*W-1:0] ppm,
  output logic [1:0] idx
);

  logic [W-1:0] m;

  // strict less-than keeps ties on the lowest index
  always_comb begin
    idx = 2'd0;
    m = ppm[W-1:0];
    for (int s = 1; s < NS; s++) begin
      if (ppm[s*W +: W] < m) begin
        m = ppm[s*W +: W];
        idx = 2'(s);
      end
    end
  end

endmodule

// File: rtl/etb_213.sv
// etb_213: Viterbi traceback survivor memory; ring buffer of
// decision vectors, fixed-depth traceback, one decoded bit each.
// Ports: clock, reset (async low), bus (etb_213_if.slave).
// ETB_BEST_STATE_EN: start from min-metric state, else state 0.
module etb_213
  import etb_213_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int W = W_DEF
) (
  input logic clock,
  input logic reset,
  etb_213_if.slave bus
);

  localparam int AW =
    (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(TB_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(TB_DEPTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(TB_DEPTH - 1);

  logic [NS-1:0] mem [TB_DEPTH];
  etb_state_e st;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] fc;
  logic [CW-1:0] cnt;
  logic [1:0] ss;
  logic [1:0] ss_nxt;
  logic [1:0] src;
  logic [1:0] cur;
  logic [1:0] cur_nxt;
  logic acc;
  logic ready_q;
  logic dout_q;
  logic dv_q;
  logic ovf_q;

`ifdef ETB_BEST_STATE_EN
  etb_best_state_213 #(.W(W)) u_best (
    .ppm (bus.acs_ppm),
    .idx (ss_nxt)
  );
`else
  logic unused_ppm;
  assign unused_ppm = ^bus.acs_ppm[NS*W-1:0];
  assign ss_nxt = 2'd0;
`endif

  assign acc = bus.ae && ready_q;
  // first step walks from the latched start state
  assign src = (cnt == '0) ? ss : cur;
  assign cur_nxt = pred(src, mem[rp][src]);

  assign bus.ready = ready_q;
  assign bus.dout = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.ovf = ovf_q;

  always_ff @(posedge clock) begin
    if (acc) mem[wp] <= bus.acs_Bx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      fc <= '0;
      cnt <= '0;
      ss <= '0;
      cur <= '0;
      ready_q <= 1'b1;
      dout_q <= 1'b0;
      dv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (bus.ae && !ready_q) ovf_q <= 1'b1;
      unique case (st)
        IDLE: begin
          if (acc) begin
            wp <= (wp == LAST) ? '0 : wp + 1'b1;
            ss <= ss_nxt;
            if (fc != FULL) fc <= fc + 1'b1;
            if (fc >= FULL_M1) begin
              st <= TRACE;
              ready_q <= 1'b0;
              rp <= wp;
              cur <= ss_nxt;
              cnt <= '0;
            end
          end
        end
        TRACE: begin
          cur <= cur_nxt;
          rp <= (rp == '0) ? LAST : rp - 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == FULL_M1) begin
            st <= EMIT;
            dv_q <= 1'b1;
            dout_q <= cur_nxt[1];
          end
        end
        EMIT: begin
          st <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          st <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
